ahb_lite_slave_mem: RTL and testbench
=====================================

AHB_LITE_SLAVE_MEM -- requirements
Module: ahb_lite_slave_mem

Interface
REQ-001 Parameters SHALL be DATAWIDTH (default 32, data bus width), ADDRWIDTH (default 32, address bus width) and SLAVE_ADDRWIDTH (default 10, log2 of memory depth in words), all taken from AHBpkg.
REQ-002 Ports SHALL be, in this order:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDRWIDTH  byte address.
- HTRANS  in  HTRANS_TYPE  transfer type.
- HBURST  in  HBURST_TYPE  burst type; accepted but unused.
- HSIZE  in  HSIZE_TYPE  transfer size.
- HWRITE  in  HWRITE_TYPE  direction.
- HWDATA  in  DATAWIDTH  write data.
- HREADY  in  1  bus-level ready.
- HRDATA  out  DATAWIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  HRESP_TYPE  response.
REQ-003 The block SHALL use one clock, HCLK, and an asynchronous active-low reset, HRESETn.

Function
REQ-004 An address phase SHALL be accepted only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; accepted HADDR, HSIZE and HWRITE are registered for the following data phase.
REQ-005 IDLE or BUSY transfers, and cycles with HSEL=0, SHALL produce a zero-wait OKAY data phase with no memory access.
REQ-006 Memory SHALL be 2**SLAVE_ADDRWIDTH words of DATAWIDTH bits, indexed by HADDR[SLAVE_ADDRWIDTH+1:2].
REQ-007 A transfer SHALL be errored when either condition holds:
- any bit of HADDR[ADDRWIDTH-1:SLAVE_ADDRWIDTH+2] is 1;
- HSIZE > WORD, or HSIZE=HALFWORD with HADDR[0]=1, or HSIZE=WORD with HADDR[1:0]!=0.
REQ-008 The state machine SHALL have states IDLE, ACCESS, ERR1 and ERR2:
- IDLE -> ACCESS on a legal accepted transfer; IDLE -> ERR1 on an errored transfer.
- ACCESS -> ACCESS or ERR1 on a new accepted transfer; otherwise ACCESS -> IDLE.
- ERR1 -> ERR2 unconditionally.
- ERR2 behaves as IDLE for the address phase sampled in that cycle.
REQ-009 In ERR1, HREADYOUT SHALL be 0 and HRESP ERROR; in ERR2, HREADYOUT SHALL be 1 and HRESP ERROR; an errored transfer SHALL never modify memory.
REQ-010 A legal data phase SHALL complete with zero wait states (HREADYOUT=1, HRESP=OKAY) unless AHB_SLAVE_WAITSTATE_EN is defined.
REQ-011 Write byte lanes SHALL be selected from the registered HADDR[1:0] and HSIZE, little-endian:
- BYTE writes lane HADDR[1:0];
- HALFWORD writes lanes {HADDR[1],0} and {HADDR[1],1};
- WORD writes all four lanes.
Unselected bytes are preserved, and memory updates at the HCLK edge ending the data phase.
REQ-012 A read SHALL drive the full addressed word on HRDATA during its completing data phase; HRDATA SHALL be 0 in non-read data phases.
REQ-013 A read whose address phase overlaps the data phase of a write to the same word SHALL return the newly written data.
REQ-014 Address-phase inputs sampled while HREADY=0 SHALL be ignored.

Reset
REQ-015 While HRESETn=0, the block SHALL hold HREADYOUT=1, HRESP=OKAY, HRDATA=0, state IDLE, and clear all registered address-phase fields.
REQ-016 Reset asserted mid-transfer SHALL abort the transfer without writing memory; memory contents are not reset.

Configuration
REQ-017 When AHB_SLAVE_WAITSTATE_EN is defined, each legal data phase SHALL insert exactly one wait state: one cycle of HREADYOUT=0 with HRESP=OKAY, then completion, giving a 2-cycle data phase.
REQ-018 When AHB_SLAVE_WAITSTATE_EN is undefined, no wait-state logic SHALL exist; error responses are identical in both builds.

Structure
REQ-019 HTRANS_TYPE, HBURST_TYPE, HSIZE_TYPE, HRESP_TYPE, HWRITE_TYPE and the width parameters SHALL come from AHBpkg, and the state enum SHALL be added to AHBpkg.
REQ-020 Byte-lane write-enable decoding SHALL be a sub-module, ahb_byte_lane_decode: inputs HSIZE and HADDR[1:0], output a 4-bit lane enable.

Verification
REQ-021 WORD write of 0xDEADBEEF to 0x10, then read of 0x10 -> HRDATA=0xDEADBEEF, HRESP=OKAY, zero waits.
REQ-022 BYTE write of 0xAA to 0x13 over word 0x11223344 -> read returns 0xAA223344.
REQ-023 Back-to-back write of 0x5 to 0x20, then read of 0x20 -> read data phase returns 0x5.
REQ-024 NONSEQ to HADDR=0x1000 -> ERR1 (HREADYOUT=0, ERROR), then ERR2 (HREADYOUT=1, ERROR); memory unchanged.
REQ-025 HRESETn dropped during a write data phase -> outputs take reset values immediately; the target word is unchanged.
REQ-026 With AHB_SLAVE_WAITSTATE_EN defined, a read -> exactly one HREADYOUT=0 cycle, then data with OKAY.

Source files
------------

// File: rtl/ahb_lite_slave_mem_pkg.sv
// AHBpkg: bus field types, width defaults and the slave state enum shared by
// ahb_lite_slave_mem and its byte-lane decoder.
package AHBpkg;

    localparam int DATAWIDTH       = 32;
    localparam int ADDRWIDTH       = 32;
    localparam int SLAVE_ADDRWIDTH = 10;

    typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} HTRANS_TYPE;
    typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} HBURST_TYPE;
    typedef enum logic [2:0] {BYTE, HALFWORD, WORD, DWORD, WORD4, WORD8, WORD16, WORD32} HSIZE_TYPE;
    typedef enum logic {OKAY, ERROR} HRESP_TYPE;
    typedef enum logic {READ, WRITE} HWRITE_TYPE;

    typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} ahb_state_t;

    // Sizes wider than a word are never legal on this 32-bit slave.
    function automatic logic size_misaligned(input HSIZE_TYPE s, input logic [1:0] a);
        case (s)
            BYTE:     return 1'b0;
            HALFWORD: return a[0];
            WORD:     return |a;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_lane.sv
// ahb_byte_lane_decode: little-endian write byte-lane enables from the
// registered transfer size and low address bits.
module ahb_byte_lane_decode
    import AHBpkg::*;
(
    input  HSIZE_TYPE   i_hsize,
    input  logic [1:0]  i_addr,
    output logic [3:0]  o_lane_en
);

    always_comb begin
        o_lane_en = 4'b0000;
        case (i_hsize)
            BYTE:     o_lane_en = 4'b0001 << i_addr;
            HALFWORD: o_lane_en = i_addr[1] ? 4'b1100 : 4'b0011;
            WORD:     o_lane_en = 4'b1111;
            default:  o_lane_en = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory slave with two-cycle ERROR response.
// Define AHB_SLAVE_WAITSTATE_EN to add one wait state to every legal data phase.
module ahb_lite_slave_mem
    import AHBpkg::*;
#(
    parameter int DATAWIDTH       = AHBpkg::DATAWIDTH,
    parameter int ADDRWIDTH       = AHBpkg::ADDRWIDTH,
    parameter int SLAVE_ADDRWIDTH = AHBpkg::SLAVE_ADDRWIDTH
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  HTRANS_TYPE           HTRANS,
    input  HBURST_TYPE           HBURST,
    input  HSIZE_TYPE            HSIZE,
    input  HWRITE_TYPE           HWRITE,
    input  logic [DATAWIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    output logic [DATAWIDTH-1:0] HRDATA,
    output logic                 HREADYOUT,
    output HRESP_TYPE            HRESP
);

    localparam int MEMDEPTH = 1 << SLAVE_ADDRWIDTH;

    ahb_state_t                 r_state;
    logic [SLAVE_ADDRWIDTH+1:0] r_addr;
    HSIZE_TYPE                  r_size;
    HWRITE_TYPE                 r_write;
    logic                       r_hreadyout;
    HRESP_TYPE                  r_hresp;
    logic [DATAWIDTH-1:0]       r_mem [MEMDEPTH];

    logic                       w_accept;
    logic                       w_err;
    logic                       w_done;
    logic                       w_stall;
    logic [3:0]                 w_lane_en;
    logic [SLAVE_ADDRWIDTH-1:0] w_idx;
    logic                       w_unused;

    assign w_accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign w_err    = (|HADDR[ADDRWIDTH-1:SLAVE_ADDRWIDTH+2]) || size_misaligned(HSIZE, HADDR[1:0]);
    assign w_idx    = r_addr[SLAVE_ADDRWIDTH+1:2];
    assign w_unused = ^HBURST;

`ifdef AHB_SLAVE_WAITSTATE_EN
    logic r_wait;
    assign w_stall = (r_state == ACCESS) && r_wait;
`else
    assign w_stall = 1'b0;
`endif
    assign w_done = (r_state == ACCESS) && !w_stall;

    ahb_byte_lane_decode u_lane (
        .i_hsize   (r_size),
        .i_addr    (r_addr[1:0]),
        .o_lane_en (w_lane_en)
    );

    // Outputs are registered alongside the state so each state's response is
    // present from the first cycle of that state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_size      <= BYTE;
            r_write     <= READ;
            r_hreadyout <= 1'b1;
            r_hresp     <= OKAY;
`ifdef AHB_SLAVE_WAITSTATE_EN
            r_wait      <= 1'b0;
`endif
        end else if (r_state == ERR1) begin
            r_state     <= ERR2;
            r_hreadyout <= 1'b1;
            r_hresp     <= ERROR;
        end else if (w_stall) begin
`ifdef AHB_SLAVE_WAITSTATE_EN
            r_wait      <= 1'b0;
`endif
            r_hreadyout <= 1'b1;
            r_hresp     <= OKAY;
        end else if (w_accept) begin
            r_addr  <= HADDR[SLAVE_ADDRWIDTH+1:0];
            r_size  <= HSIZE;
            r_write <= HWRITE;
            if (w_err) begin
                r_state     <= ERR1;
                r_hreadyout <= 1'b0;
                r_hresp     <= ERROR;
            end else begin
                r_state     <= ACCESS;
                r_hresp     <= OKAY;
`ifdef AHB_SLAVE_WAITSTATE_EN
                r_wait      <= 1'b1;
                r_hreadyout <= 1'b0;
`else
                r_hreadyout <= 1'b1;
`endif
            end
        end else begin
            r_state     <= IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= OKAY;
        end
    end

    // Written at the edge closing the data phase, so an overlapping read of the
    // same word picks up the new value through the asynchronous read below.
    always_ff @(posedge HCLK) begin
        if (w_done && r_write == WRITE) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lane_en[b]) r_mem[w_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA    = (w_done && r_write == READ) ? r_mem[w_idx] : '0;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Randomized bench for ahb_lite_slave_mem against a transaction-level memory model.
module tb_ahb_lite_slave_mem;
    import AHBpkg::*;

`ifdef AHB_SLAVE_WAITSTATE_EN
    localparam bit WS = 1'b1;
`else
    localparam bit WS = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    HTRANS_TYPE  HTRANS;
    HBURST_TYPE  HBURST;
    HSIZE_TYPE   HSIZE;
    HWRITE_TYPE  HWRITE;
    logic [31:0] HWDATA;
    wire         HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    HRESP_TYPE   HRESP;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_lite_slave_mem dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        bit          write;
        logic [31:0] wdata;
        bit          has_exp;
        logic [31:0] exp;
        bit          real_x;
    } xfer_t;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mdl [16];
    xfer_t       q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(bit sel, logic [1:0] trans, logic [31:0] addr,
                                 logic [2:0] size, bit write, logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.addr = addr; x.size = size;
        x.write = write; x.wdata = wdata; x.has_exp = 1'b0; x.exp = '0; x.real_x = 1'b1;
        return x;
    endfunction

    function automatic xfer_t pad();
        xfer_t x = mk(1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
        x.real_x = 1'b0;
        return x;
    endfunction

    function automatic xfer_t rd_exp(logic [31:0] addr, logic [31:0] exp);
        xfer_t x = mk(1'b1, 2'd2, addr, 3'd2, 1'b0, 32'd0);
        x.has_exp = 1'b1; x.exp = exp;
        return x;
    endfunction

    function automatic bit active(xfer_t x);
        return x.sel && x.trans[1];
    endfunction

    // Error rule: out-of-range upper address bits, oversize, or misaligned.
    function automatic bit bad(xfer_t x);
        return (x.addr[31:12] != 0) || (x.size > 3'd2) ||
               (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'd0);
    endfunction

    function automatic int dlen(xfer_t x);
        if (!active(x)) return 1;
        if (bad(x)) return 2;
        return WS ? 2 : 1;
    endfunction

    function automatic void mdl_write(xfer_t x);
        int nb = 1 << x.size;
        for (int i = 0; i < nb; i++) begin
            int lane = int'(x.addr[1:0]) + i;
            mdl[x.addr[5:2]][8*lane +: 8] = x.wdata[8*lane +: 8];
        end
    endfunction

    task automatic drive_addr(input xfer_t x);
        logic [2:0] hb = 3'($urandom_range(0, 7));
        HSEL   = x.sel;
        HADDR  = x.addr;
        HTRANS = HTRANS_TYPE'(x.trans);
        HSIZE  = HSIZE_TYPE'(x.size);
        HWRITE = HWRITE_TYPE'(x.write);
        HBURST = HBURST_TYPE'(hb);
    endtask

    task automatic check_phase(input xfer_t d, input int k, input bit last);
        logic        e_rdy  = 1'b1;
        logic        e_resp = 1'b0;
        logic [31:0] e_rd   = '0;
        bit          c_rd   = 1'b1;
        if (active(d) && bad(d)) begin
            e_rdy = (k != 0); e_resp = 1'b1;
        end else if (active(d)) begin
            e_rdy = WS ? (k != 0) : 1'b1;
            if (!d.write) begin
                if (last) e_rd = d.has_exp ? d.exp : mdl[d.addr[5:2]];
                else c_rd = 1'b0;
            end
        end
        chk($sformatf("hreadyout@%h", d.addr), 32'(HREADYOUT), 32'(e_rdy));
        chk($sformatf("hresp@%h", d.addr), 32'(HRESP), 32'(e_resp));
        if (c_rd) chk($sformatf("hrdata@%h", d.addr), HRDATA, e_rd);
    endtask

    // Pipelined master: address phase of 'a' overlaps the data phase of 'd'.
    // Non-final data-phase cycles carry junk that HREADY=0 must hide.
    task automatic run_q();
        xfer_t d = pad();
        xfer_t a = pad();
        xfer_t j;
        int    k = 0;
        int    total = q.size();
        int    done_n = 0;
        bit    last;
        if (q.size() > 0) a = q.pop_front();
        while (done_n < total) begin
            last = (k == dlen(d) - 1);
            if (last) drive_addr(a);
            else begin
                j = mk(1'b1, 2'd2, $urandom, 3'($urandom_range(0, 7)), 1'($urandom), $urandom);
                drive_addr(j);
            end
            HWDATA = d.wdata;
            @(negedge HCLK);
            check_phase(d, k, last);
            @(posedge HCLK);
            if (last) begin
                if (active(d) && !bad(d) && d.write) mdl_write(d);
                if (d.real_x) done_n++;
                d = a; k = 0;
                a = (q.size() > 0) ? q.pop_front() : pad();
            end else k++;
            #1;
        end
        drive_addr(pad());
    endtask

    function automatic xfer_t rand_x();
        int          r = $urandom_range(0, 99);
        logic [2:0]  sz = 3'($urandom_range(0, 2));
        logic [31:0] ad = 32'($urandom_range(0, 63));
        xfer_t       x = mk(1'b1, 2'($urandom_range(2, 3)), '0, sz, 1'($urandom), $urandom);
        if (r < 10) begin
            x.sel = 1'b0; x.trans = 2'($urandom); x.addr = $urandom;
        end else if (r < 20) begin
            x.trans = 2'($urandom_range(0, 1)); x.addr = $urandom;
        end else if (r < 35) begin
            case ($urandom_range(0, 3))
                0: x.addr = (ad & ~((32'd1 << sz) - 1)) | (32'd1 << $urandom_range(12, 31));
                1: begin x.size = 3'd1; x.addr = ad | 32'd1; end
                2: begin x.size = 3'd2; x.addr = (ad & ~32'd3) | 32'($urandom_range(1, 3)); end
                default: begin x.size = 3'($urandom_range(3, 7)); x.addr = ad; end
            endcase
        end else begin
            x.addr = ad & ~((32'd1 << sz) - 1);
        end
        return x;
    endfunction

    logic [31:0] saved;

    initial begin
        HRESETn = 1'b0;
        HWDATA  = '0;
        drive_addr(pad());
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        for (int i = 0; i < 16; i++) q.push_back(mk(1'b1, 2'd2, 32'(i * 4), 3'd2, 1'b1, $urandom));
        q.push_back(mk(1'b1, 2'd2, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF));
        q.push_back(rd_exp(32'h10, 32'hDEADBEEF));
        q.push_back(mk(1'b1, 2'd2, 32'h10, 3'd2, 1'b1, 32'h11223344));
        q.push_back(mk(1'b1, 2'd2, 32'h13, 3'd0, 1'b1, 32'hAA000000));
        q.push_back(rd_exp(32'h10, 32'hAA223344));
        q.push_back(mk(1'b1, 2'd2, 32'h20, 3'd2, 1'b1, 32'h5));
        q.push_back(rd_exp(32'h20, 32'h5));
        q.push_back(mk(1'b1, 2'd2, 32'h1000, 3'd2, 1'b1, 32'hFFFFFFFF));
        q.push_back(mk(1'b1, 2'd2, 32'h0, 3'd2, 1'b0, 32'd0));
        run_q();

        for (int i = 0; i < 400; i++) q.push_back(rand_x());
        run_q();

        // Reset in the middle of a write data phase must abort it.
        saved = mdl[12];
        drive_addr(mk(1'b1, 2'd2, 32'h30, 3'd2, 1'b1, 32'd0));
        @(posedge HCLK); #1;
        drive_addr(pad());
        HWDATA = ~saved;
        #2 HRESETn = 1'b0;
        #1;
        chk("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("midrst_hresp", 32'(HRESP), 32'd0);
        chk("midrst_hrdata", HRDATA, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        q.push_back(rd_exp(32'h30, saved));
        q.push_back(mk(1'b1, 2'd2, 32'h30, 3'd2, 1'b0, 32'd0));
        run_q();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
